// File: rtl/mem_req_arbiter_pkg.sv
// Shared types for the DRAM channel arbiter: request/response beats and requester IDs.
package mem_req_arbiter_pkg;

  localparam int unsigned MAX_REQ = 4;

  typedef logic [1:0] req_id_t;

  typedef struct packed {
    logic         valid;
    logic         is_write;
    logic [63:0]  addr;
    logic [511:0] data;
  } mem_req_t;

  typedef struct packed {
    logic         valid;
    logic [511:0] data;
  } mem_resp_t;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Requester-side and channel-side bundle of the arbiter; slave is the arbiter view.
interface mem_req_arbiter_if #(
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned LOG_TAG_DEPTH = 6
);
  import mem_req_arbiter_pkg::*;

  mem_req_t                 req_in [NUM_REQ];
  logic [NUM_REQ-1:0]       req_grant_out;
  mem_resp_t                resp_out [NUM_REQ];
  logic [NUM_REQ-1:0]       resp_grant_in;
  mem_req_t                 mem_req_out;
  logic                     mem_req_grant_in;
  mem_resp_t                mem_resp_in;
  logic                     mem_resp_grant_out;
  logic [LOG_TAG_DEPTH:0]   outstanding_out;
  logic                     stray_resp_out;

  modport slave (
    input  req_in, resp_grant_in, mem_req_grant_in, mem_resp_in,
    output req_grant_out, resp_out, mem_req_out, mem_resp_grant_out,
           outstanding_out, stray_resp_out
  );

  modport master (
    output req_in, resp_grant_in, mem_req_grant_in, mem_resp_in,
    input  req_grant_out, resp_out, mem_req_out, mem_resp_grant_out,
           outstanding_out, stray_resp_out
  );

endinterface

// File: rtl/mem_req_arbiter_id_fifo.sv
// Show-ahead synchronous FIFO holding the requester ID of each read in flight.
module mem_req_arbiter_id_fifo #(
  parameter int unsigned WIDTH     = 2,
  parameter int unsigned LOG_DEPTH = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [WIDTH-1:0]   din,
  input  logic               pop,
  output logic [WIDTH-1:0]   dout,
  output logic               full,
  output logic               empty,
  output logic [LOG_DEPTH:0] level
);

  localparam logic [LOG_DEPTH:0] DEPTH = {1'b1, {LOG_DEPTH{1'b0}}};

  logic [WIDTH-1:0]     mem [2**LOG_DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr;
  logic [LOG_DEPTH-1:0] rd_ptr;
  logic                 wr_en;
  logic                 rd_en;

  assign full  = (level == DEPTH);
  assign empty = (level == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter with burst hold sharing one DRAM channel; in-order read
// responses are steered back to their issuer via a requester-ID FIFO.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned BURST_LEN     = 8,
  parameter int unsigned LOG_TAG_DEPTH = 6
) (
  input logic              clk,
  input logic              rst,
  mem_req_arbiter_if.slave bus
);

  localparam logic [7:0] BURST_MAX = 8'(BURST_LEN);

  req_id_t                owner;
  logic [7:0]             burst_cnt;
  logic                   stray;
  logic [MAX_REQ-1:0]     elig;
  logic [MAX_REQ-1:0]     rg;
  mem_req_t               req_pad [MAX_REQ];
  mem_req_t               fwd;
  req_id_t                sel;
  logic                   sel_found;
  logic                   accept;
  logic                   push;
  logic                   pop;
  logic                   resp_live;
  req_id_t                head;
  logic                   idq_full;
  logic                   idq_empty;
  logic [LOG_TAG_DEPTH:0] level;

  // Owner keeps the grant while under its burst budget; otherwise search
  // owner+1 onwards, with owner itself considered last.
  function automatic logic [2:0] rr_select(input logic [MAX_REQ-1:0] el,
                                           input req_id_t own,
                                           input logic [7:0] cnt);
    logic    found;
    req_id_t pick;
    req_id_t idx;
    found = 1'b0;
    pick  = own;
    if (el[own] && cnt < BURST_MAX) begin
      found = 1'b1;
    end else begin
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        idx = req_id_t'((32'(own) + k) % NUM_REQ);
        if (!found && el[idx]) begin
          found = 1'b1;
          pick  = idx;
        end
      end
    end
    return {found, pick};
  endfunction

  always_comb begin
    elig = '0;
    rg   = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) req_pad[i] = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_pad[i] = bus.req_in[i];
      rg[i]      = bus.resp_grant_in[i];
      elig[i]    = bus.req_in[i].valid && (bus.req_in[i].is_write || !idq_full);
    end

    {sel_found, sel} = rr_select(elig, owner, burst_cnt);
    fwd    = req_pad[sel];
    accept = !rst && sel_found && bus.mem_req_grant_in;
    push   = accept && !fwd.is_write;

    resp_live = !rst && bus.mem_resp_in.valid && !idq_empty;
    pop       = resp_live && rg[head];

    bus.mem_req_out       = fwd;
    bus.mem_req_out.valid = !rst && sel_found;
    // Strays are drained unconditionally so they cannot wedge the channel.
    bus.mem_resp_grant_out = pop || (!rst && bus.mem_resp_in.valid && idq_empty);
    bus.outstanding_out    = level;
    bus.stray_resp_out     = stray;
    bus.req_grant_out      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      bus.req_grant_out[i]  = accept && (i == 32'(sel));
      bus.resp_out[i].valid = resp_live && (i == 32'(head));
      bus.resp_out[i].data  = bus.mem_resp_in.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= '0;
      burst_cnt <= '0;
      stray     <= 1'b0;
    end else begin
      if (accept) begin
        if (sel == owner) begin
          if (burst_cnt < BURST_MAX) burst_cnt <= burst_cnt + 1'b1;
        end else begin
          owner     <= sel;
          burst_cnt <= 8'd1;
        end
      end else if (!elig[owner]) begin
        burst_cnt <= '0;
      end
      if (bus.mem_resp_in.valid && idq_empty) stray <= 1'b1;
    end
  end

  mem_req_arbiter_id_fifo #(
    .WIDTH     ($bits(req_id_t)),
    .LOG_DEPTH (LOG_TAG_DEPTH)
  ) u_id_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (sel),
    .pop   (pop),
    .dout  (head),
    .full  (idq_full),
    .empty (idq_empty),
    .level (level)
  );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench: stimulus queues expected channel requests and routed
// responses; a negedge monitor pops and compares on every handshake.
module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;

  localparam int unsigned NREQ = 2;
  localparam int unsigned LOGD = 6;
  localparam logic [63:0] DMASK = 64'h5A5A_0000_0000_C3C3;

  typedef struct packed {
    logic [1:0]  id;
    logic        is_write;
    logic [63:0] addr;
  } exp_req_t;

  typedef struct packed {
    logic [1:0]  id;
    logic [63:0] data;
  } exp_resp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_req_arbiter_if #(.NUM_REQ(NREQ), .LOG_TAG_DEPTH(LOGD)) bus ();

  mem_req_arbiter #(
    .NUM_REQ       (NREQ),
    .BURST_LEN     (8),
    .LOG_TAG_DEPTH (LOGD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_req_t    req_q[$];
  exp_resp_t   resp_q[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic mem_req_t mk_req(input logic w, input logic [63:0] a);
    return '{valid: 1'b1, is_write: w, addr: a, data: {8{a ^ DMASK}}};
  endfunction

  function automatic mem_resp_t mk_resp(input logic [63:0] d);
    return '{valid: 1'b1, data: {8{d}}};
  endfunction

  always @(negedge clk) begin : monitor
    logic [1:0] gid;
    exp_req_t   er;
    exp_resp_t  es;
    if (!rst) begin
      if (bus.mem_req_out.valid && bus.mem_req_grant_in) begin
        gid = 2'd3;
        for (int i = 0; i < NREQ; i++) if (bus.req_grant_out[i]) gid = 2'(i);
        if (req_q.size() == 0) begin
          chk("unexpected_req", 64'(gid), 64'hFFFF);
        end else begin
          er = req_q.pop_front();
          chk("req_id", 64'(gid), 64'(er.id));
          chk("req_is_write", 64'(bus.mem_req_out.is_write), 64'(er.is_write));
          chk("req_addr", bus.mem_req_out.addr, er.addr);
          chk("req_data", bus.mem_req_out.data[63:0], er.addr ^ DMASK);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (bus.resp_out[i].valid && bus.resp_grant_in[i]) begin
          if (resp_q.size() == 0) begin
            chk("unexpected_resp", 64'(i), 64'hFFFF);
          end else begin
            es = resp_q.pop_front();
            chk("resp_port", 64'(i), 64'(es.id));
            chk("resp_data", bus.resp_out[i].data[511:448], es.data);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int i = 0; i < NREQ; i++) bus.req_in[i] = '0;
    bus.resp_grant_in    = '0;
    bus.mem_req_grant_in = 1'b0;
    bus.mem_resp_in      = '0;
  endtask

  // Inputs are left busy during reset to show that outputs stay gated.
  task automatic do_reset();
    rst = 1'b1;
    bus.req_in[0]        = mk_req(1'b1, 64'hDEAD);
    bus.mem_req_grant_in = 1'b1;
    bus.mem_resp_in      = mk_resp(64'hBEEF);
    bus.resp_grant_in    = '1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req_valid", 64'(bus.mem_req_out.valid), 64'd0);
    chk("rst_req_grant", 64'(bus.req_grant_out), 64'd0);
    chk("rst_mem_resp_grant", 64'(bus.mem_resp_grant_out), 64'd0);
    chk("rst_outstanding", 64'(bus.outstanding_out), 64'd0);
    chk("rst_stray", 64'(bus.stray_resp_out), 64'd0);
    cyc();
    rst = 1'b0;
    idle();
  endtask

  initial begin
    logic [63:0] a;
    logic [1:0]  ids [3];
    logic [63:0] ds  [3];
    rst = 1'b1;
    idle();
    do_reset();

    // Single write stream from requester 0
    bus.mem_req_grant_in = 1'b1;
    for (int k = 0; k < 20; k++) begin
      a = 64'h1000 + 64'(k) * 64;
      bus.req_in[0] = mk_req(1'b1, a);
      req_q.push_back('{id: 2'd0, is_write: 1'b1, addr: a});
      @(negedge clk);
      chk("t1_grant0", 64'(bus.req_grant_out), 64'd1);
      cyc();
    end
    idle();
    @(negedge clk);
    chk("t1_outstanding", 64'(bus.outstanding_out), 64'd0);
    cyc();

    // Burst rotation: 8 x req0, 8 x req1, 8 x req0
    do_reset();
    bus.mem_req_grant_in = 1'b1;
    bus.req_in[0] = mk_req(1'b1, 64'h10000);
    bus.req_in[1] = mk_req(1'b1, 64'h20000);
    for (int n = 0; n < 24; n++) begin
      if (n >= 8 && n < 16) req_q.push_back('{id: 2'd1, is_write: 1'b1, addr: 64'h20000});
      else                  req_q.push_back('{id: 2'd0, is_write: 1'b1, addr: 64'h10000});
      @(negedge clk);
      chk("t2_grant", 64'(bus.req_grant_out), (n >= 8 && n < 16) ? 64'd2 : 64'd1);
      cyc();
    end
    idle();

    // Read routing A(req0), B(req1), C(req0)
    do_reset();
    bus.mem_req_grant_in = 1'b1;
    ids[0] = 2'd0; ids[1] = 2'd1; ids[2] = 2'd0;
    ds[0] = 64'hD1D1_0001; ds[1] = 64'hD2D2_0002; ds[2] = 64'hD3D3_0003;
    for (int j = 0; j < 3; j++) begin
      a = 64'hA00 + 64'(j) * 64'h100;
      bus.req_in[0] = '0;
      bus.req_in[1] = '0;
      bus.req_in[ids[j]] = mk_req(1'b0, a);
      req_q.push_back('{id: ids[j], is_write: 1'b0, addr: a});
      cyc();
    end
    idle();
    @(negedge clk);
    chk("t3_outstanding3", 64'(bus.outstanding_out), 64'd3);
    cyc();
    bus.resp_grant_in = '1;
    for (int j = 0; j < 3; j++) begin
      bus.mem_resp_in = mk_resp(ds[j]);
      resp_q.push_back('{id: ids[j], data: ds[j]});
      @(negedge clk);
      chk("t3_resp_grant", 64'(bus.mem_resp_grant_out), 64'd1);
      cyc();
    end
    idle();
    @(negedge clk);
    chk("t3_outstanding0", 64'(bus.outstanding_out), 64'd0);
    cyc();

    // Tag full: 64 reads from req1, then a write slips past the blocked read
    do_reset();
    bus.mem_req_grant_in = 1'b1;
    bus.req_in[1] = mk_req(1'b0, 64'h3000);
    for (int k = 0; k < 64; k++) begin
      req_q.push_back('{id: 2'd1, is_write: 1'b0, addr: 64'h3000});
      cyc();
    end
    bus.req_in[0] = mk_req(1'b1, 64'h4000);
    req_q.push_back('{id: 2'd0, is_write: 1'b1, addr: 64'h4000});
    @(negedge clk);
    chk("t4_outstanding64", 64'(bus.outstanding_out), 64'd64);
    chk("t4_write_past_full", 64'(bus.req_grant_out), 64'd1);
    cyc();
    bus.req_in[0] = '0;
    bus.mem_resp_in   = mk_resp(64'hFEED_0040);
    bus.resp_grant_in = 2'b10;
    resp_q.push_back('{id: 2'd1, data: 64'hFEED_0040});
    req_q.push_back('{id: 2'd1, is_write: 1'b0, addr: 64'h3000});
    @(negedge clk);
    chk("t4_read_blocked", 64'(bus.req_grant_out), 64'd0);
    chk("t4_pop_grant", 64'(bus.mem_resp_grant_out), 64'd1);
    cyc();
    bus.mem_resp_in = '0;
    @(negedge clk);
    chk("t4_read_resumes", 64'(bus.req_grant_out), 64'd2);
    cyc();
    idle();
    @(negedge clk);
    chk("t4_outstanding_refill", 64'(bus.outstanding_out), 64'd64);
    cyc();

    // Head-of-line stall with head ID 1
    do_reset();
    bus.mem_req_grant_in = 1'b1;
    bus.req_in[1] = mk_req(1'b0, 64'h5000);
    req_q.push_back('{id: 2'd1, is_write: 1'b0, addr: 64'h5000});
    cyc();
    bus.req_in[1] = '0;
    bus.req_in[0] = mk_req(1'b0, 64'h5100);
    req_q.push_back('{id: 2'd0, is_write: 1'b0, addr: 64'h5100});
    cyc();
    idle();
    bus.mem_resp_in   = mk_resp(64'hE1E1);
    bus.resp_grant_in = 2'b01;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t5_stall_grant", 64'(bus.mem_resp_grant_out), 64'd0);
      chk("t5_stall_valid0", 64'(bus.resp_out[0].valid), 64'd0);
      chk("t5_stall_valid1", 64'(bus.resp_out[1].valid), 64'd1);
      cyc();
    end
    bus.resp_grant_in = 2'b11;
    resp_q.push_back('{id: 2'd1, data: 64'hE1E1});
    @(negedge clk);
    chk("t5_release_grant", 64'(bus.mem_resp_grant_out), 64'd1);
    cyc();
    bus.mem_resp_in = mk_resp(64'hE2E2);
    resp_q.push_back('{id: 2'd0, data: 64'hE2E2});
    @(negedge clk);
    chk("t5_second_valid0", 64'(bus.resp_out[0].valid), 64'd1);
    cyc();
    idle();
    @(negedge clk);
    chk("t5_outstanding0", 64'(bus.outstanding_out), 64'd0);
    cyc();

    // Reset with reads in flight: late responses become drained strays
    do_reset();
    bus.mem_req_grant_in = 1'b1;
    for (int j = 0; j < 3; j++) begin
      a = 64'h6000 + 64'(j) * 64;
      bus.req_in[0] = mk_req(1'b0, a);
      req_q.push_back('{id: 2'd0, is_write: 1'b0, addr: a});
      cyc();
    end
    idle();
    @(negedge clk);
    chk("t6_outstanding3", 64'(bus.outstanding_out), 64'd3);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_cleared", 64'(bus.outstanding_out), 64'd0);
    chk("t6_stray_before", 64'(bus.stray_resp_out), 64'd0);
    cyc();
    bus.resp_grant_in = '1;
    for (int j = 0; j < 3; j++) begin
      bus.mem_resp_in = mk_resp(64'h5700 + 64'(j));
      @(negedge clk);
      chk("t6_drain_grant", 64'(bus.mem_resp_grant_out), 64'd1);
      chk("t6_no_fwd0", 64'(bus.resp_out[0].valid), 64'd0);
      chk("t6_no_fwd1", 64'(bus.resp_out[1].valid), 64'd0);
      cyc();
    end
    idle();
    @(negedge clk);
    chk("t6_stray_set", 64'(bus.stray_resp_out), 64'd1);
    chk("t6_outstanding0", 64'(bus.outstanding_out), 64'd0);
    chk("req_queue_drained", 64'(req_q.size()), 64'd0);
    chk("resp_queue_drained", 64'(resp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares one simplified DRAM channel (MemReq/MemResp handshake, the DramInterleaver input side) between NUM_REQ independent requesters, e.g. a PCIe-to-DRAM streamer and a DRAM-to-PCIe reader.
- Round-robin arbitration with a configurable burst hold, so back-to-back writes from one requester stay contiguous.
- Read responses return in order from the channel. They are routed back to the issuing requester through an internal requester-ID FIFO.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- BURST_LEN, 8, maximum consecutive grants to one requester before priority rotates (1..255).
- LOG_TAG_DEPTH, 6, log2 of outstanding-read tracking depth (64 reads in flight).

Ports:
- clk  in  1  user clock.
- rst  in  1  synchronous, active-high reset.
- req_in  in  MemReq[NUM_REQ]  requester requests {valid, isWrite, addr[63:0], data[511:0]}.
- req_grant_out  out  1[NUM_REQ]  request accepted this cycle.
- resp_out  out  MemResp[NUM_REQ]  routed read responses {valid, data[511:0]}.
- resp_grant_in  in  1[NUM_REQ]  requester consumes response.
- mem_req_out  out  MemReq  to channel / interleaver.
- mem_req_grant_in  in  1  channel accepts mem_req_out.
- mem_resp_in  in  MemResp  read data from channel.
- mem_resp_grant_out  out  1  pop channel response.
- outstanding_out  out  LOG_TAG_DEPTH+1  reads issued, not yet returned.
- stray_resp_out  out  1  sticky: a response arrived with no tracked read.

Behaviour:
- Reset (clk edge with rst=1):
  - owner=0, burst_cnt=0, ID FIFO empty, outstanding_out=0, stray_resp_out=0.
  - All valid/grant outputs are 0 while rst=1.
- Arbitration is combinational on registered state:
  - Eligible(i) = req_in[i].valid && (req_in[i].isWrite || !idq_full).
  - If Eligible(owner) and burst_cnt < BURST_LEN, select owner.
  - Otherwise select the first eligible index searching owner+1, owner+2, … modulo NUM_REQ, with owner itself searched last.
  - No eligible requester: mem_req_out.valid=0.
- Forwarding: mem_req_out = req_in[sel] unmodified. req_grant_out[sel] = mem_req_grant_in; all other grants are 0. Zero added latency.
- On each accepted request (valid && mem_req_grant_in):
  - If sel==owner: burst_cnt++.
  - Else: owner<=sel, burst_cnt<=1.
  - If isWrite=0: push sel into the ID FIFO and increment outstanding.
- Burst release: if owner is not eligible in a cycle, burst_cnt<=0 so the next grant goes round-robin from owner+1.
- Ties: none possible. Exactly one requester is selected per cycle.
- Writes never touch the ID FIFO. Writes are still granted when the ID FIFO is full.
- Response routing:
  - When mem_resp_in.valid && !idq_empty: resp_out[head].valid=1 with data passed through.
  - mem_resp_grant_out = resp_grant_in[head]. Pop the ID FIFO and decrement outstanding on grant.
  - All other resp_out[].valid=0.
- Stray response: mem_resp_in.valid && idq_empty → set stray_resp_out and assert mem_resp_grant_out to drain the response. Nothing is forwarded.
- Simultaneous push and pop in one cycle: outstanding unchanged, FIFO order preserved.
- ID FIFO full (outstanding = 2^LOG_TAG_DEPTH): reads are blocked and writes continue. A blocked read owner loses the burst hold via burst release.
- Reset mid-operation clears tracking. Responses to pre-reset reads then arrive as strays: they are drained and flagged, never delivered. Software clears the flag with rst.
- Backpressure: a requester not asserting resp_grant_in stalls all responses (head-of-line). This is required for in-order channels.

Decomposition:
- Shared package (MemArbTypes): ReqId typedef (logic[1:0]); constant MAX_REQ=4. MemReq/MemResp come from ShellTypes.
- Sub-module: mem_arb_id_fifo. Synchronous FIFO, WIDTH=$bits(ReqId), depth 2^LOG_TAG_DEPTH, show-ahead output, full/empty flags. Alternatively the existing FIFO primitive is instantiated directly.
- RR selection is a local function, not a separate module.

Test Plan:
- Single write stream: req0 issues 20 writes, mem_req_grant_in=1 → 20 grants to req0 in 20 cycles, addresses unchanged, outstanding stays 0.
- Burst rotation: both requesters continuously valid, BURST_LEN=8 → grant pattern 8×req0, 8×req1, 8×req0; no requester starves.
- Read routing: req0 reads A, req1 reads B, req0 reads C; responses D1, D2, D3 returned in order → resp_out[0] gets D1 then D3, resp_out[1] gets D2; outstanding returns to 0.
- Tag full: 64 reads from req1 with no responses → 65th read not granted, req0 write still granted; one response popped → read granted the next cycle.
- Head-of-line stall: head ID=1, resp_grant_in[1]=0 for 10 cycles → mem_resp_grant_out=0 for those cycles, resp_out[0].valid=0; release → pops.
- Reset mid-flight: 3 reads outstanding, pulse rst, then 3 responses arrive → none forwarded, mem_resp_grant_out=1 for each, stray_resp_out=1.
